// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit flag encodings, flit field offsets, a ceiling log2
// and the injector FSM state type.
package noc_pkg;

  localparam logic [1:0] HDR_FLG  = 2'b10;
  localparam logic [1:0] TAIL_FLG = 2'b01;

  // Flit layout, LSB first: payload, one-hot VC, then the {hdr,tail} flags.
  localparam int unsigned PAY_LSB = 0;

  function automatic int unsigned vc_lsb(input int unsigned fpay);
    return fpay;
  endfunction

  function automatic int unsigned flg_lsb(input int unsigned v, input int unsigned fpay);
    return fpay + v;
  endfunction

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic [0:0] {StIdle, StSend} inj_state_e;

endpackage

// File: rtl/noc_pkt_injector_if.sv
// Descriptor, flit and credit signals of the packet injector.
// master: injector side; slave: traffic source / downstream router side.
interface noc_pkt_injector_if import noc_pkg::*; #(
    parameter int unsigned V           = 2,
    parameter int unsigned Fpay        = 32,
    parameter int unsigned MAX_PKT_LEN = 16
);
    localparam int unsigned Lw = log2(MAX_PKT_LEN + 1);
    localparam int unsigned Fw = 2 + V + Fpay;

    logic            pkt_req;
    logic            pkt_ready;
    logic [V-1:0]    pkt_vc;
    logic [Lw-1:0]   pkt_len;
    logic [Fpay-1:0] pkt_hdr;
    logic [Fpay-1:0] data_base;
    logic [Fw-1:0]   flit_out;
    logic            flit_out_we;
    logic [V-1:0]    credit_in;
    logic            credit_err;
    logic [15:0]     sent_pkt_cnt;

    modport master (
        input  pkt_req, pkt_vc, pkt_len, pkt_hdr, data_base, credit_in,
        output pkt_ready, flit_out, flit_out_we, credit_err, sent_pkt_cnt
    );

    modport slave (
        output pkt_req, pkt_vc, pkt_len, pkt_hdr, data_base, credit_in,
        input  pkt_ready, flit_out, flit_out_we, credit_err, sent_pkt_cnt
    );
endinterface

// File: rtl/noc_credit_counter.sv
// Per-VC credit counter: starts at B, -1 per flit sent, +1 per returned credit,
// saturating at B with an overflow pulse when a credit arrives while full.
module noc_credit_counter import noc_pkg::*; #(
    parameter int unsigned B = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dec_i,
    input  logic inc_i,
    output logic avail_o,
    output logic overflow_o
);
    localparam int unsigned Cw = log2(B + 1);

    logic [Cw-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d      = cnt_q;
        overflow_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q == Cw'(B)) overflow_o = 1'b1;
                else                 cnt_d      = cnt_q + Cw'(1);
            end
            // dec_i is only raised while the count is nonzero.
            2'b01:   cnt_d = cnt_q - Cw'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign avail_o = (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= Cw'(B);
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/noc_pkt_injector.sv
// Credit-based NoC packet injector: turns one descriptor into a header/body/tail flit stream.
// Define NOC_PKT_INJECTOR_STAT_EN to build the sent-packet counter.
module noc_pkt_injector import noc_pkg::*; #(
    parameter int unsigned V           = 2,
    parameter int unsigned B           = 4,
    parameter int unsigned Fpay        = 32,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input logic               clk,
    input logic               reset,
    noc_pkt_injector_if.master bus
);
    localparam int unsigned Lw     = log2(MAX_PKT_LEN + 1);
    localparam int unsigned Fw     = 2 + V + Fpay;
    localparam int unsigned VcLsb  = vc_lsb(Fpay);
    localparam int unsigned FlgLsb = flg_lsb(V, Fpay);

    inj_state_e      state_q, state_d;
    logic [V-1:0]    vc_q, vc_d;
    logic [Lw-1:0]   len_q, len_d;
    logic [Lw-1:0]   idx_q, idx_d;
    logic [Fpay-1:0] hdr_q, hdr_d;
    logic [Fpay-1:0] base_q, base_d;
    logic [Fw-1:0]   flit_q, flit_d;
    logic            we_q, we_d;
    logic            credit_err_q;

    logic [V-1:0]    vc_avail, vc_ovf, vc_dec;
    logic [Lw-1:0]   len_clamp;
    logic [1:0]      flags;
    logic [Fpay-1:0] payload;
    logic            send_fire, is_hdr, is_tail;

    for (genvar i = 0; i < V; i++) begin : g_vc
        noc_credit_counter #(.B(B)) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .dec_i      (vc_dec[i]),
            .inc_i      (bus.credit_in[i]),
            .avail_o    (vc_avail[i]),
            .overflow_o (vc_ovf[i])
        );
    end

    always_comb begin
        len_clamp = bus.pkt_len;
        if (bus.pkt_len == '0)                    len_clamp = Lw'(1);
        else if (bus.pkt_len > Lw'(MAX_PKT_LEN))  len_clamp = Lw'(MAX_PKT_LEN);
    end

    assign is_hdr    = (idx_q == '0);
    assign is_tail   = (idx_q == len_q - Lw'(1));
    assign send_fire = (state_q == StSend) && (|(vc_q & vc_avail));
    assign vc_dec    = send_fire ? vc_q : '0;
    assign flags     = (is_hdr ? HDR_FLG : 2'b00) | (is_tail ? TAIL_FLG : 2'b00);
    // Flit i (i >= 1) carries data_base + (i - 1).
    assign payload   = is_hdr ? hdr_q : base_q + Fpay'(idx_q) - Fpay'(1);

    always_comb begin
        state_d = state_q;
        vc_d    = vc_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hdr_d   = hdr_q;
        base_d  = base_q;
        flit_d  = flit_q;
        we_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.pkt_req) begin
                    state_d = StSend;
                    vc_d    = bus.pkt_vc;
                    len_d   = len_clamp;
                    idx_d   = '0;
                    hdr_d   = bus.pkt_hdr;
                    base_d  = bus.data_base;
                end
            end
            StSend: begin
                if (send_fire) begin
                    we_d                     = 1'b1;
                    flit_d[FlgLsb +: 2]      = flags;
                    flit_d[VcLsb +: V]       = vc_q;
                    flit_d[PAY_LSB +: Fpay]  = payload;
                    idx_d                    = idx_q + Lw'(1);
                    if (is_tail) state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            vc_q         <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            hdr_q        <= '0;
            base_q       <= '0;
            flit_q       <= '0;
            we_q         <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vc_q         <= vc_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            hdr_q        <= hdr_d;
            base_q       <= base_d;
            flit_q       <= flit_d;
            we_q         <= we_d;
            credit_err_q <= credit_err_q | (|vc_ovf);
        end
    end

    assign bus.pkt_ready   = (state_q == StIdle);
    assign bus.flit_out    = flit_q;
    assign bus.flit_out_we = we_q;
    assign bus.credit_err  = credit_err_q;

`ifdef NOC_PKT_INJECTOR_STAT_EN
    logic [15:0] sent_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                    sent_cnt_q <= '0;
        else if (send_fire && is_tail) sent_cnt_q <= sent_cnt_q + 16'd1;
    end

    assign bus.sent_pkt_cnt = sent_cnt_q;
`else
    assign bus.sent_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_noc_pkt_injector.sv
// Directed self-checking bench for noc_pkt_injector (V=2, B=4, Fpay=32, MAX_PKT_LEN=16).
module tb_noc_pkt_injector;
    localparam int unsigned V = 2, B = 4, Fpay = 32, MaxLen = 16;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    noc_pkt_injector_if #(.V(V), .Fpay(Fpay), .MAX_PKT_LEN(MaxLen)) bus ();

    noc_pkt_injector #(.V(V), .B(B), .Fpay(Fpay), .MAX_PKT_LEN(MaxLen)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [1:0] vc, input logic [4:0] len,
                             input logic [31:0] hdr, input logic [31:0] base);
        bus.pkt_vc    = vc;
        bus.pkt_len   = len;
        bus.pkt_hdr   = hdr;
        bus.data_base = base;
        bus.pkt_req   = 1'b1;
        tick();
        bus.pkt_req   = 1'b0;
    endtask

    task automatic give_credits(input logic [1:0] vc, input int n);
        for (int i = 0; i < n; i++) begin
            bus.credit_in = vc;
            tick();
        end
        bus.credit_in = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus.pkt_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b want 1", bus.pkt_ready); end
        checks++; if (bus.flit_out_we !== 1'b0) begin errors++;
            $display("FAIL reset_we: got %b want 0", bus.flit_out_we); end
        checks++; if (bus.flit_out !== 36'h0) begin errors++;
            $display("FAIL reset_flit: got %h want 0", bus.flit_out); end
        checks++; if (bus.credit_err !== 1'b0) begin errors++;
            $display("FAIL reset_err: got %b want 0", bus.credit_err); end
        checks++; if (bus.sent_pkt_cnt !== 16'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d want 0", bus.sent_pkt_cnt); end
    endtask

    task automatic test_basic();
        logic [35:0] tbl [4];
        tbl = '{36'h9_00084433, 36'h1_AB000000, 36'h1_AB000001, 36'h5_AB000002};
        send_desc(2'b01, 5'd4, 32'h00084433, 32'hAB000000);
        checks++; if (bus.pkt_ready !== 1'b0) begin errors++;
            $display("FAIL basic_busy: got ready=%b want 0", bus.pkt_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.credit_in = 2'b00;
            checks++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== tbl[i]) begin errors++;
                $display("FAIL basic_flit%0d: got we=%b %h want we=1 %h",
                         i, bus.flit_out_we, bus.flit_out, tbl[i]); end
            bus.credit_in = 2'b01;
        end
        tick();
        bus.credit_in = 2'b00;
        checks++; if (bus.flit_out_we !== 1'b0 || bus.pkt_ready !== 1'b1) begin errors++;
            $display("FAIL basic_end: got we=%b ready=%b want we=0 ready=1",
                     bus.flit_out_we, bus.pkt_ready); end
    endtask

    task automatic test_stall();
        logic [35:0] tbl [6];
        int n;
        bit got;
        tbl = '{36'h9_00000055, 36'h1_00000100, 36'h1_00000101,
                36'h1_00000102, 36'h1_00000103, 36'h5_00000104};
        send_desc(2'b01, 5'd6, 32'h55, 32'h100);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.flit_out_we) begin
                if (n < 6) begin
                    checks++; if (bus.flit_out !== tbl[n]) begin errors++;
                        $display("FAIL stall_flit%0d: got %h want %h", n, bus.flit_out, tbl[n]); end
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++;
            $display("FAIL stall_count: got %0d flits want 4", n); end
        checks++; if (bus.flit_out_we !== 1'b0 || bus.flit_out !== tbl[3]) begin errors++;
            $display("FAIL stall_hold: got we=%b %h want we=0 %h",
                     bus.flit_out_we, bus.flit_out, tbl[3]); end
        // A descriptor offered mid-packet must be ignored.
        bus.pkt_vc = 2'b10; bus.pkt_len = 5'd1; bus.pkt_hdr = 32'hBAD; bus.pkt_req = 1'b1;
        tick();
        bus.pkt_req = 1'b0;
        checks++; if (bus.pkt_ready !== 1'b0) begin errors++;
            $display("FAIL stall_busy: got ready=%b want 0", bus.pkt_ready); end
        for (int k = 4; k < 6; k++) begin
            bus.credit_in = 2'b01;
            tick();
            bus.credit_in = 2'b00;
            got = 1'b0;
            for (int i = 0; i < 2 && !got; i++) begin
                tick();
                got = bus.flit_out_we;
            end
            checks++; if (!got || bus.flit_out !== tbl[k]) begin errors++;
                $display("FAIL stall_resume%0d: got we=%b %h want we=1 %h",
                         k, got, bus.flit_out, tbl[k]); end
        end
        bus.credit_in = 2'b01;
        tick();
        checks++; if (bus.flit_out_we !== 1'b0 || bus.pkt_ready !== 1'b1) begin errors++;
            $display("FAIL stall_end: got we=%b ready=%b want we=0 ready=1",
                     bus.flit_out_we, bus.pkt_ready); end
        give_credits(2'b01, 3);
    endtask

    task automatic test_single();
        send_desc(2'b10, 5'd1, 32'hDEADBEEF, 32'h0);
        tick();
        checks++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== 36'hE_DEADBEEF) begin errors++;
            $display("FAIL single_flit: got we=%b %h want we=1 %h",
                     bus.flit_out_we, bus.flit_out, 36'hE_DEADBEEF); end
        checks++; if (bus.pkt_ready !== 1'b1) begin errors++;
            $display("FAIL single_ready: got %b want 1", bus.pkt_ready); end
        give_credits(2'b10, 1);
    endtask

    task automatic test_len_clamp();
        int n;
        bit done;
        logic [35:0] last;
        send_desc(2'b01, 5'd0, 32'h77, 32'h0);
        tick();
        checks++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== 36'hD_00000077) begin errors++;
            $display("FAIL len0_flit: got we=%b %h want we=1 %h",
                     bus.flit_out_we, bus.flit_out, 36'hD_00000077); end
        give_credits(2'b01, 1);
        send_desc(2'b10, 5'd31, 32'h88, 32'h90);
        n = 0; done = 1'b0; last = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            bus.credit_in = 2'b00;
            if (bus.flit_out_we) begin
                n++;
                last = bus.flit_out;
                done = bus.flit_out[34];
                bus.credit_in = 2'b10;
            end
        end
        tick();
        bus.credit_in = 2'b00;
        checks++; if (n != 16) begin errors++;
            $display("FAIL lenmax_count: got %0d flits want 16", n); end
        checks++; if (last !== 36'h6_0000009E) begin errors++;
            $display("FAIL lenmax_tail: got %h want %h", last, 36'h6_0000009E); end
    endtask

    task automatic test_credit_simul();
        int n;
        bit got;
        send_desc(2'b01, 5'd3, 32'h11, 32'h20);
        tick();
        tick();
        bus.credit_in = 2'b01;  // lands with the tail flit, counter at 2
        tick();
        bus.credit_in = 2'b00;
        checks++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== 36'h5_00000021) begin errors++;
            $display("FAIL simul_tail: got we=%b %h want we=1 %h",
                     bus.flit_out_we, bus.flit_out, 36'h5_00000021); end
        send_desc(2'b01, 5'd3, 32'h22, 32'h30);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.flit_out_we) n++;
        end
        checks++; if (n != 2) begin errors++;
            $display("FAIL simul_count: got %0d flits want 2", n); end
        give_credits(2'b01, 1);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            if (bus.flit_out_we) got = 1'b1;
            else tick();
        end
        checks++; if (!got || bus.flit_out !== 36'h5_00000031) begin errors++;
            $display("FAIL simul_resume: got we=%b %h want we=1 %h",
                     got, bus.flit_out, 36'h5_00000031); end
        give_credits(2'b01, 4);

        checks++; if (bus.credit_err !== 1'b0) begin errors++;
            $display("FAIL err_clear: got %b want 0", bus.credit_err); end
        give_credits(2'b10, 1);
        checks++; if (bus.credit_err !== 1'b1) begin errors++;
            $display("FAIL err_set: got %b want 1", bus.credit_err); end
        tick(); tick(); tick();
        checks++; if (bus.credit_err !== 1'b1) begin errors++;
            $display("FAIL err_sticky: got %b want 1", bus.credit_err); end
        send_desc(2'b10, 5'd5, 32'h33, 32'h40);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.flit_out_we) n++;
        end
        checks++; if (n != 4) begin errors++;
            $display("FAIL err_saturate: got %0d flits want 4", n); end
        give_credits(2'b10, 1);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            if (bus.flit_out_we) got = 1'b1;
            else tick();
        end
        checks++; if (!got || bus.flit_out !== 36'h6_00000043) begin errors++;
            $display("FAIL err_tail: got we=%b %h want we=1 %h",
                     got, bus.flit_out, 36'h6_00000043); end
        give_credits(2'b10, 4);
    endtask

    task automatic test_reset_mid();
        logic [35:0] tbl [3];
        tbl = '{36'h9_00000066, 36'h1_00000070, 36'h5_00000071};
        send_desc(2'b01, 5'd5, 32'h44, 32'h50);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.flit_out_we !== 1'b0 || bus.flit_out !== 36'h0) begin errors++;
            $display("FAIL mid_we: got we=%b %h want we=0 0", bus.flit_out_we, bus.flit_out); end
        checks++; if (bus.pkt_ready !== 1'b1 || bus.credit_err !== 1'b0) begin errors++;
            $display("FAIL mid_state: got ready=%b err=%b want ready=1 err=0",
                     bus.pkt_ready, bus.credit_err); end
        send_desc(2'b01, 5'd3, 32'h66, 32'h70);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.flit_out_we !== 1'b1 || bus.flit_out !== tbl[i]) begin errors++;
                $display("FAIL mid_flit%0d: got we=%b %h want we=1 %h",
                         i, bus.flit_out_we, bus.flit_out, tbl[i]); end
        end
        give_credits(2'b01, 3);
    endtask

    task automatic test_stats();
        logic [4:0]  lens [3];
        logic [1:0]  vcs  [3];
        logic [15:0] exp_cnt;
        bit done;
        lens = '{5'd1, 5'd2, 5'd1};
        vcs  = '{2'b01, 2'b10, 2'b01};
`ifdef NOC_PKT_INJECTOR_STAT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.sent_pkt_cnt !== 16'd0) begin errors++;
            $display("FAIL stats_reset: got %0d want 0", bus.sent_pkt_cnt); end
        for (int p = 0; p < 3; p++) begin
            send_desc(vcs[p], lens[p], 32'h100 + p, 32'h200);
            done = 1'b0;
            for (int i = 0; i < 6 && !done; i++) begin
                tick();
                bus.credit_in = 2'b00;
                if (bus.flit_out_we) begin
                    done = bus.flit_out[34];
                    bus.credit_in = vcs[p];
                end
            end
            tick();
            bus.credit_in = 2'b00;
        end
        checks++; if (bus.sent_pkt_cnt !== exp_cnt) begin errors++;
            $display("FAIL stats_count: got %0d want %0d", bus.sent_pkt_cnt, exp_cnt); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.pkt_req   = 1'b0;
        bus.pkt_vc    = '0;
        bus.pkt_len   = '0;
        bus.pkt_hdr   = '0;
        bus.data_base = '0;
        bus.credit_in = '0;
        test_reset();
        test_basic();
        test_stall();
        test_single();
        test_len_clamp();
        test_credit_simul();
        test_reset_mid();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/noc_pkt_injector.md
NOC_PKT_INJECTOR -- requirements
Module: noc_pkt_injector

Interface
REQ-001 SHALL have parameter V, default 2, number of virtual channels per port.
REQ-002 SHALL have parameter B, default 4, buffer depth in flits per VC of the downstream router.
REQ-003 SHALL have parameter Fpay, default 32, flit payload width.
REQ-004 SHALL have parameter MAX_PKT_LEN, default 16, maximum packet length in flits; Lw=log2(MAX_PKT_LEN+1); Fw=2+V+Fpay.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pkt_req  input  1  packet descriptor valid.
REQ-008 SHALL have port pkt_ready  output  1  injector idle, can accept a descriptor.
REQ-009 SHALL have port pkt_vc  input  V  one-hot target VC.
REQ-010 SHALL have port pkt_len  input  Lw  packet length in flits, header included.
REQ-011 SHALL have port pkt_hdr  input  Fpay  header flit payload.
REQ-012 SHALL have port data_base  input  Fpay  payload seed for non-header flits.
REQ-013 SHALL have port flit_out  output  Fw  flit: [Fw-1:Fw-2] {hdr,tail} flags, [Fpay+V-1:Fpay] one-hot VC, [Fpay-1:0] payload.
REQ-014 SHALL have port flit_out_we  output  1  flit_out valid this cycle.
REQ-015 SHALL have port credit_in  input  V  one-hot credit return per VC, one credit per set bit per cycle.
REQ-016 SHALL have port credit_err  output  1  sticky: credit received on a VC already holding B credits.
REQ-017 SHALL have port sent_pkt_cnt  output  16  completed packets counter (see REQ-033).

Function
REQ-018 SHALL accept a descriptor on a cycle where pkt_req and pkt_ready are both high, capturing pkt_vc, pkt_len, pkt_hdr, data_base.
REQ-019 SHALL implement FSM states IDLE, SEND; IDLE->SEND on accept; SEND->IDLE on the cycle the tail flit is registered; pkt_ready high only in IDLE.
REQ-020 SHALL treat pkt_len=0 as 1 and pkt_len>MAX_PKT_LEN as MAX_PKT_LEN.
REQ-021 SHALL keep one credit counter per VC, width log2(B+1), initialised to B.
REQ-022 SHALL in SEND register one flit per cycle only when the selected VC's counter is nonzero; flit_out_we is registered, earliest header one cycle after accept.
REQ-023 SHALL set flags 2'b10 on header, 2'b00 on body, 2'b01 on tail, 2'b11 on a single-flit packet.
REQ-024 SHALL carry pkt_hdr in the header payload and data_base+(i-1) (mod 2^Fpay) in flit i, i=1..len-1.
REQ-025 SHALL decrement a VC counter by 1 per flit sent on it and increment by 1 per credit_in bit; simultaneous send and credit on the same VC leaves it unchanged.
REQ-026 SHALL saturate a counter at B when a credit arrives at B and set credit_err, which stays high until reset.
REQ-027 SHALL emit the next flit within 2 cycles of a credit_in pulse unblocking a stalled VC at 0.
REQ-028 SHALL hold flit_out stable and flit_out_we low while stalled; a new descriptor is ignored while not in IDLE.

Reset
REQ-029 SHALL on reset: FSM=IDLE, pkt_ready=1 next cycle, flit_out=0, flit_out_we=0, credit counters=B, credit_err=0, sent_pkt_cnt=0.
REQ-030 SHALL on reset mid-packet abandon the packet with no tail flit, flit_out_we low the cycle after reset is sampled.

Configuration
REQ-031 SHALL compile statistics only when macro NOC_PKT_INJECTOR_STAT_EN is defined.
REQ-032 SHALL, with the macro, increment sent_pkt_cnt (wrapping at 2^16) on each tail flit registered.
REQ-033 SHALL, without the macro, tie sent_pkt_cnt to 0 with no counter logic.

Structure
REQ-034 SHALL place flag encodings HDR_FLG/TAIL_FLG, flit field offsets and a log2 function in shared package noc_pkg.
REQ-035 SHALL use one sub-module noc_credit_counter, instantiated V times, one per VC.

Verification
REQ-036 V=2,B=4: len=4, vc=2'b01, hdr=0x00084433, base=0xAB000000, credits returned 1 cycle after each flit -> 4 consecutive flits, flags 10/00/00/01, payloads 0x00084433, 0xAB000000, 0xAB000001, 0xAB000002.
REQ-037 len=6, no credits returned -> exactly 4 flits then flit_out_we low; one credit_in=2'b01 -> 5th flit within 2 cycles.
REQ-038 len=1 -> one flit, flags 2'b11, payload pkt_hdr; pkt_ready high again next cycle.
REQ-039 credit_in=2'b01 on the cycle a VC0 flit is sent with counter 2 -> counter stays 2; credit_in=2'b10 with VC1 counter 4 -> counter 4, credit_err=1 and stays high.
REQ-040 reset asserted after 2 of 5 flits -> flit_out_we 0 next cycle, counters return to 4, pkt_ready=1; new len=3 packet sends full 3 flits.
REQ-041 with NOC_PKT_INJECTOR_STAT_EN, 3 packets sent -> sent_pkt_cnt=3; without it -> 0.
